i2s_clkgen: RTL and testbench
=============================

Name: i2s_clkgen

Overview:
Parametrised I2S master timing generator. Derives the serial bit clock (sclk) from pclk using any integer ratio, and generates the word-select signal (ws) for 16/24/32-bit channel slots. Provides single-pclk strobes and a bit index for the transmitter and receiver shift logic. Configuration is applied glitch-free only at frame boundaries. Sits between the control register block and the tx/rx serialisers.

Parameters:
DIV_W, 8, width of the pclk-to-sclk divide ratio input.
IDX_W, 5, width of the bit_idx output; must hold 31.

Ports:
pclk  in  1  system clock; all logic on posedge.
rst_  in  1  asynchronous, active-low reset.
en  in  1  run request.
div  in  DIV_W  pclk cycles per sclk period; values 0 and 1 are treated as 2.
frame_size  in  frame_t  channel slot length: f16bits, f24bits or f32bits.
sclk  out  1  bit clock, registered.
ws  out  1  word select: 0 = left channel, 1 = right channel. Registered.
sclk_rise  out  1  high for one pclk, in the first cycle sclk reads 1.
sclk_fall  out  1  high for one pclk, in the first cycle sclk reads 0.
ws_change  out  1  high for one pclk, in the first cycle ws shows its new value.
bit_idx  out  IDX_W  bit position in the current channel; 0 = MSB slot.
busy  out  1  high while in RUN.

Behaviour:
- Reset (async, any time including mid-run): state=IDLE; sclk=0, ws=1, all strobes 0, bit_idx=0, busy=0, counters 0.
- State IDLE: sclk=0, ws=1. When en=1 is sampled:
  - latch div_q (clamped to ≥2) and len_q (16/24/32) from the inputs;
  - next cycle: state=RUN, busy=1, ws=0, ws_change=1, bit_idx=0, div_cnt=0.
- State RUN, divider:
  - div_cnt counts 0..div_q-1 and wraps.
  - LO = ceil(div_q/2). sclk is 0 while div_cnt<LO and 1 otherwise.
  - Low phase is LO cycles; high phase is floor(div_q/2) cycles. Odd ratios give the longer low phase; no negedge logic is used.
  - The first sclk rise comes LO pclk cycles after ws drops.
- State RUN, bit/ws logic (evaluated on each sclk fall):
  - If bit_idx==len_q-1: bit_idx wraps to 0, ws toggles, and ws_change is asserted in the same cycle as sclk_fall.
  - Otherwise bit_idx increments.
  - bit_idx and ws update in the same cycle sclk drops.
- Frame boundary: the sclk fall where ws toggles 1→0.
  - Only here are div and frame_size resampled.
  - Changes at any other time have no effect until the next boundary.
- Stop: en is sampled at each frame boundary.
  - If en=0, do not toggle ws. Go to IDLE with ws staying 1 and sclk=0; busy drops in that same cycle. No ws_change is generated.
  - A frame in progress always completes both channels.
  - Deasserting en and reasserting it before the boundary has no effect.
- Restart: from IDLE, en=1 restarts per the IDLE rule; minimum one IDLE cycle between frames.
- Simultaneous events: a config change exactly at the boundary cycle is taken. en=0 takes priority over config resampling.

Decomposition:
- ctrl_pkg:
  - extend frame_t with f24bits;
  - add function slot_len(frame_t) returning 16/24/32;
  - add localparam DIV_MIN=2.
- Sub-module i2s_sclk_div: div_cnt and sclk register with rise/fall strobes. Inputs are run and div_q.
- Top level holds the FSM, bit_idx, ws, and the config latch.

Test Plan:
- div=4, f16bits, en=1: sclk period 4 pclk (2 low/2 high). ws toggles every 16 sclk (64 pclk). ws_change coincides with sclk_fall. bit_idx runs 0..15.
- div=5, f24bits: sclk 3 low/2 high. ws half-period 24 sclk = 120 pclk. bit_idx wraps at 23.
- div=0 and div=1: identical to div=2 (1 low/1 high), no stalled clock.
- Change div 4→6 and f16→f32 mid left channel: old timing holds through the right channel; the new period (6) and 32-bit slots start exactly at the ws 1→0 boundary.
- en drops 10 sclk into the left channel: the full frame completes (32 sclk for f16). Then sclk=0, ws=1, busy=0, with no extra edge and no ws_change.
- rst_ asserted mid-high-phase: sclk=0, ws=1, busy=0 immediately (async). After release with en=1, first ws=0 is one cycle later and the first sclk rise LO cycles after that.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types, limits and slot-length helper for the i2s timing block
package ctrl_pkg;

  // Channel slot lengths supported by the serialisers
  typedef enum logic [1:0] {
    f16bits = 2'd0,
    f24bits = 2'd1,
    f32bits = 2'd2
  } frame_t;

  // Generator run state
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Smallest usable pclk-to-sclk ratio; smaller requests are raised to this
  localparam int DIV_MIN = 2;

  // Width wide enough to hold the longest slot length (32)
  localparam int SLOT_W = 6;

  // Number of bit clocks per channel slot; the unused encoding falls back to 32
  function automatic logic [SLOT_W-1:0] slot_len(input frame_t f);
    logic [SLOT_W-1:0] len;
    case (f)
      f16bits: len = SLOT_W'(16);
      f24bits: len = SLOT_W'(24);
      default: len = SLOT_W'(32);
    endcase
    return len;
  endfunction

endpackage

// File: rtl/i2s_sclk_div.sv
// rtl/i2s_sclk_div.sv - integer pclk divider producing registered sclk and edge strobes
module i2s_sclk_div
  import ctrl_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             pclk,
  input  logic             rst_,
  input  logic             run,
  input  logic [DIV_W-1:0] div_q,
  output logic             sclk,
  output logic             sclk_rise,
  output logic             sclk_fall,
  output logic             fall_next
);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W:0]   lo;
  logic             wrap;

  // Low phase is ceil(div/2) so odd ratios stretch the low half; wrap marks the
  // last count of the period, i.e. the next edge drops sclk
  always_comb begin
    lo        = ({1'b0, div_q} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    wrap      = (div_cnt == (div_q - DIV_W'(1)));
    cnt_nxt   = wrap ? '0 : (div_cnt + DIV_W'(1));
    fall_next = run && wrap;
  end

  // Counter and sclk are held at zero outside RUN so every run starts at count 0, sclk low
  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      div_cnt   <= '0;
      sclk      <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
    end else if (!run) begin
      div_cnt   <= '0;
      sclk      <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
    end else begin
      div_cnt   <= cnt_nxt;
      sclk      <= ({1'b0, cnt_nxt} >= lo);
      sclk_rise <= ({1'b0, cnt_nxt} == lo);
      sclk_fall <= wrap;
    end
  end

endmodule

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - I2S master timing generator: sclk, ws, strobes and bit index
module i2s_clkgen
  import ctrl_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int IDX_W = 5
) (
  input  logic             pclk,
  input  logic             rst_,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  frame_t           frame_size,
  output logic             sclk,
  output logic             ws,
  output logic             sclk_rise,
  output logic             sclk_fall,
  output logic             ws_change,
  output logic [IDX_W-1:0] bit_idx,
  output logic             busy
);

  state_t            state_q, state_d;
  logic              ws_q, ws_d;
  logic              ws_change_q, ws_change_d;
  logic [IDX_W-1:0]  bit_q, bit_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [SLOT_W-1:0] len_q, len_d;
  logic [DIV_W-1:0]  div_clamped;
  logic              run;
  logic              fall_next;
  logic              last_bit;

  assign run = (state_q == RUN);

  // Raise ratios below the minimum so the divider never stalls
  always_comb begin
    div_clamped = (div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div;
    last_bit    = (bit_q == IDX_W'(len_q - SLOT_W'(1)));
  end

  i2s_sclk_div #(
    .DIV_W(DIV_W)
  ) u_sclk_div (
    .pclk      (pclk),
    .rst_      (rst_),
    .run       (run),
    .div_q     (div_q),
    .sclk      (sclk),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .fall_next (fall_next)
  );

  // Next-state logic: start on en, advance bit/ws on each sclk fall, and only at the
  // right-to-left boundary either stop (en low) or take new configuration
  always_comb begin
    state_d     = state_q;
    ws_d        = ws_q;
    ws_change_d = 1'b0;
    bit_d       = bit_q;
    div_d       = div_q;
    len_d       = len_q;
    case (state_q)
      IDLE: begin
        ws_d  = 1'b1;
        bit_d = '0;
        if (en) begin
          state_d     = RUN;
          ws_d        = 1'b0;
          ws_change_d = 1'b1;
          div_d       = div_clamped;
          len_d       = slot_len(frame_size);
        end
      end
      RUN: begin
        if (fall_next) begin
          if (last_bit) begin
            bit_d = '0;
            if (!ws_q) begin
              ws_d        = 1'b1;
              ws_change_d = 1'b1;
            end else if (!en) begin
              state_d = IDLE;
              ws_d    = 1'b1;
            end else begin
              ws_d        = 1'b0;
              ws_change_d = 1'b1;
              div_d       = div_clamped;
              len_d       = slot_len(frame_size);
            end
          end else begin
            bit_d = bit_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        ws_d    = 1'b1;
        bit_d   = '0;
      end
    endcase
  end

  // State, word-select, bit index and latched configuration registers
  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= IDLE;
      ws_q        <= 1'b1;
      ws_change_q <= 1'b0;
      bit_q       <= '0;
      div_q       <= DIV_W'(DIV_MIN);
      len_q       <= slot_len(f16bits);
    end else begin
      state_q     <= state_d;
      ws_q        <= ws_d;
      ws_change_q <= ws_change_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      len_q       <= len_d;
    end
  end

  assign ws        = ws_q;
  assign ws_change = ws_change_q;
  assign bit_idx   = bit_q;
  assign busy      = run;

endmodule

// File: tb/tb_i2s_clkgen.sv
// tb/tb_i2s_clkgen.sv - directed self-checking bench for i2s_clkgen
module tb_i2s_clkgen;
  import ctrl_pkg::*;

  logic       pclk;
  logic       rst_;
  logic       en;
  logic [7:0] div;
  frame_t     frame_size;
  logic       sclk;
  logic       ws;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       ws_change;
  logic [4:0] bit_idx;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int n, mx, hi, lo, cc;

  i2s_clkgen #(
    .DIV_W(8),
    .IDX_W(5)
  ) dut (
    .pclk       (pclk),
    .rst_       (rst_),
    .en         (en),
    .div        (div),
    .frame_size (frame_size),
    .sclk       (sclk),
    .ws         (ws),
    .sclk_rise  (sclk_rise),
    .sclk_fall  (sclk_fall),
    .ws_change  (ws_change),
    .bit_idx    (bit_idx),
    .busy       (busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next ws_change; returns cycles taken and highest bit_idx seen
  task automatic wait_chg(input string tag, output int cyc, output int maxidx);
    cyc = 0;
    maxidx = 0;
    do begin
      tick();
      cyc++;
      if (int'(bit_idx) > maxidx) maxidx = int'(bit_idx);
    end while (ws_change !== 1'b1 && cyc < 400);
    chk({tag, "_seen"}, ws_change, 1);
  endtask

  task automatic wait_rise(input string tag, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (sclk_rise !== 1'b1 && cyc < 400);
    chk({tag, "_seen"}, sclk_rise, 1);
  endtask

  // From an sclk_rise sample: cycles to the fall, then cycles to the next rise
  task automatic measure(output int h, output int l);
    h = 0;
    l = 0;
    do begin tick(); h++; end while (sclk_fall !== 1'b1 && h < 400);
    do begin tick(); l++; end while (sclk_rise !== 1'b1 && l < 400);
  endtask

  // Advance until busy drops; counts ws_change strobes on the way
  task automatic wait_idle(input string tag, output int cyc, output int chg);
    cyc = 0;
    chg = 0;
    do begin
      tick();
      cyc++;
      if (ws_change === 1'b1) chg++;
    end while (busy !== 1'b0 && cyc < 600);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst_ = 1'b0;
    en = 1'b0;
    div = 8'd4;
    frame_size = f16bits;
    tick();
    tick();
    chk("rst_sclk", sclk, 0);
    chk("rst_ws", ws, 1);
    chk("rst_busy", busy, 0);
    chk("rst_bit_idx", bit_idx, 0);
    chk("rst_strobes", {sclk_rise, sclk_fall, ws_change}, 0);

    // div=4, 16-bit slots
    @(negedge pclk);
    rst_ = 1'b1;
    en = 1'b1;
    tick();
    chk("start_ws", ws, 0);
    chk("start_ws_change", ws_change, 1);
    chk("start_busy", busy, 1);
    chk("start_bit_idx", bit_idx, 0);
    chk("start_sclk", sclk, 0);
    wait_chg("d4_left", n, mx);
    chk("d4_left_len", n, 64);
    chk("d4_left_maxidx", mx, 15);
    chk("d4_left_ws", ws, 1);
    chk("d4_chg_with_fall", sclk_fall, 1);
    chk("d4_chg_sclk", sclk, 0);
    wait_rise("d4_rise", n);
    chk("d4_first_rise", n, 2);
    measure(hi, lo);
    chk("d4_high", hi, 2);
    chk("d4_low", lo, 2);
    wait_chg("d4_right", n, mx);
    chk("d4_boundary_ws", ws, 0);
    chk("d4_boundary_bit_idx", bit_idx, 0);

    // Reconfigure mid left channel: new timing only from the next boundary
    div = 8'd6;
    frame_size = f32bits;
    wait_chg("cfg_left", n, mx);
    chk("cfg_left_len", n, 64);
    wait_chg("cfg_right", n, mx);
    chk("cfg_right_len", n, 64);
    chk("cfg_boundary_ws", ws, 0);
    wait_chg("d6_left", n, mx);
    chk("d6_left_len", n, 192);
    chk("d6_left_maxidx", mx, 31);
    wait_rise("d6_rise", n);
    chk("d6_first_rise", n, 3);
    measure(hi, lo);
    chk("d6_high", hi, 3);
    chk("d6_low", lo, 3);

    // Back to div=4/f16 at the next boundary, then stop 10 sclk into the left channel
    div = 8'd4;
    frame_size = f16bits;
    wait_chg("d6_right", n, mx);
    chk("d6_right_rest", n, 183);
    chk("d6_boundary_ws", ws, 0);
    repeat (40) tick();
    en = 1'b0;
    wait_idle("stop", n, cc);
    chk("stop_len", n, 88);
    chk("stop_chg_count", cc, 1);
    chk("stop_ws", ws, 1);
    chk("stop_sclk", sclk, 0);
    chk("stop_no_chg", ws_change, 0);
    cc = 0;
    repeat (8) begin
      tick();
      if (sclk_rise === 1'b1 || sclk === 1'b1 || ws_change === 1'b1) cc++;
    end
    chk("idle_quiet", cc, 0);
    chk("idle_ws", ws, 1);

    // div=0 behaves as 2; en glitch before the boundary is ignored
    div = 8'd0;
    en = 1'b1;
    tick();
    chk("d0_start_chg", ws_change, 1);
    wait_chg("d0_left", n, mx);
    chk("d0_left_len", n, 32);
    chk("d0_left_maxidx", mx, 15);
    wait_rise("d0_rise", n);
    chk("d0_first_rise", n, 1);
    measure(hi, lo);
    chk("d0_high", hi, 1);
    chk("d0_low", lo, 1);
    en = 1'b0;
    tick();
    en = 1'b1;
    wait_chg("d0_right", n, mx);
    chk("d0_right_rest", n, 28);
    chk("glitch_ws", ws, 0);
    chk("glitch_busy", busy, 1);

    // div=1 behaves as 2, restart after a single idle cycle
    en = 1'b0;
    div = 8'd1;
    wait_idle("d0_stop", n, cc);
    chk("d0_stop_len", n, 64);
    en = 1'b1;
    tick();
    chk("d1_start_chg", ws_change, 1);
    chk("d1_start_busy", busy, 1);
    wait_chg("d1_left", n, mx);
    chk("d1_left_len", n, 32);
    wait_rise("d1_rise", n);
    chk("d1_first_rise", n, 1);
    measure(hi, lo);
    chk("d1_high", hi, 1);
    chk("d1_low", lo, 1);

    // div=5, 24-bit slots
    en = 1'b0;
    div = 8'd5;
    frame_size = f24bits;
    wait_idle("d1_stop", n, cc);
    chk("d1_stop_len", n, 29);
    chk("d1_stop_chg_count", cc, 0);
    en = 1'b1;
    tick();
    chk("d5_start_chg", ws_change, 1);
    wait_chg("d5_left", n, mx);
    chk("d5_left_len", n, 120);
    chk("d5_left_maxidx", mx, 23);
    chk("d5_chg_with_fall", sclk_fall, 1);
    wait_rise("d5_rise", n);
    chk("d5_first_rise", n, 3);
    measure(hi, lo);
    chk("d5_high", hi, 2);
    chk("d5_low", lo, 3);

    // Asynchronous reset during the high phase
    chk("pre_rst_sclk", sclk, 1);
    rst_ = 1'b0;
    #1;
    chk("arst_sclk", sclk, 0);
    chk("arst_ws", ws, 1);
    chk("arst_busy", busy, 0);
    chk("arst_bit_idx", bit_idx, 0);
    @(negedge pclk);
    rst_ = 1'b1;
    tick();
    chk("rerun_ws", ws, 0);
    chk("rerun_chg", ws_change, 1);
    wait_rise("rerun_rise", n);
    chk("rerun_first_rise", n, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
